// File: rtl/det_nxn_seq_if.sv
// det_nxn_seq_if: request/result bundle between the operation decoder and the determinant engine
interface det_nxn_seq_if #(parameter int W = 8);
  logic start;
  logic [1:0] size;
  logic sat_en;
  logic [16*W-1:0] matriz;
  logic busy;
  logic done;
  logic [W-1:0] det;
  logic overflow;
  logic error;
  modport master(output start, size, sat_en, matriz, input busy, done, det, overflow, error);
  modport slave(input start, size, sat_en, matriz, output busy, done, det, overflow, error);
endinterface

// File: rtl/det_nxn_seq.sv
// det_nxn_seq: sequential Leibniz determinant engine for 2x2/3x3/4x4 matrices on one shared MAC
module det_nxn_seq #(parameter int W = 8) (
  input logic clk,
  input logic rst,
  det_nxn_seq_if.slave bus
);
  localparam int AW = 4*W+5;
  localparam int PW = 4*W;
  localparam logic signed [AW-1:0] MAXV = AW'(2**(W-1)-1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  // Lexicographic permutations, p(0) in the top digit; sign bits set for odd parity
  localparam logic [23:0][7:0] P4 = {8'hE4, 8'hE1, 8'hD8, 8'hD2, 8'hC9, 8'hC6, 8'hB4, 8'hB1,
                                     8'h9C, 8'h93, 8'h8D, 8'h87, 8'h78, 8'h72, 8'h6C, 8'h63,
                                     8'h4E, 8'h4B, 8'h39, 8'h36, 8'h2D, 8'h27, 8'h1E, 8'h1B};
  localparam logic [7:0][5:0] P3 = {6'd0, 6'd0, 6'd36, 6'd33, 6'd24, 6'd18, 6'd9, 6'd6};
  localparam logic [1:0][3:0] P2 = {4'h4, 4'h1};
  localparam logic [23:0] S4 = 24'h666666;
  localparam logic [7:0] S3 = 8'h26;
  localparam logic [1:0] S2 = 2'b10;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_st;
  logic [16*W-1:0] r_mat;
  logic [1:0] r_sz;
  logic r_sat;
  logic signed [AW-1:0] r_acc;
  logic signed [PW-1:0] r_pr;
  logic [4:0] r_t;
  logic [1:0] r_k;
  logic r_busy, r_done, r_ovf, r_err;
  logic [W-1:0] r_det;
  logic signed [W-1:0] w_m [16];
  logic [7:0] w_code;
  logic [1:0] w_col;
  logic w_neg, w_kl, w_tl, w_hi, w_lo;
  logic signed [W-1:0] w_a;
  logic signed [PW-1:0] w_ax, w_prod;
  logic signed [AW-1:0] w_acc;
  logic [W-1:0] w_det;
  for (genvar i = 0; i < 16; i++) begin : g_m
    assign w_m[i] = r_mat[W*(16-i)-1 -: W];
  end
  always_comb begin
    w_code = r_sz == 2'd2 ? P4[r_t] : r_sz == 2'd1 ? {P3[r_t[2:0]], 2'b00} : {P2[r_t[0]], 4'b0000};
    w_neg = r_sz == 2'd2 ? S4[r_t] : r_sz == 2'd1 ? S3[r_t[2:0]] : S2[r_t[0]];
    w_col = w_code[{2'd3 - r_k, 1'b0} +: 2];
    w_a = w_m[{r_k, w_col}];
    w_ax = {{(PW-W){w_a[W-1]}}, w_a};
    w_prod = r_pr * w_ax;
    w_acc = w_neg ? r_acc - AW'(w_prod) : r_acc + AW'(w_prod);
    w_kl = r_k == r_sz + 2'd1;
    w_tl = r_t == (r_sz == 2'd2 ? 5'd23 : r_sz == 2'd1 ? 5'd5 : 5'd1);
    w_hi = w_acc > MAXV;
    w_lo = w_acc < MINV;
    w_det = r_sat && w_hi ? MAXV[W-1:0] : r_sat && w_lo ? MINV[W-1:0] : w_acc[W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= IDLE;
      r_mat <= '0;
      r_sz <= '0;
      r_sat <= 1'b0;
      r_acc <= '0;
      r_pr <= '0;
      r_t <= '0;
      r_k <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_det <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_st)
        IDLE: if (bus.start) begin
          r_mat <= bus.matriz;
          r_sz <= bus.size;
          r_sat <= bus.sat_en;
          r_acc <= '0;
          r_pr <= '0;
          r_t <= '0;
          r_k <= '0;
          r_busy <= 1'b1;
          if (bus.size == 2'b11) begin
            r_st <= DONE;
            r_done <= 1'b1;
            r_det <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b1;
          end else r_st <= CALC;
        end
        CALC: if (r_k == 2'd0) begin
          r_pr <= w_ax;
          r_k <= r_k + 2'd1;
        end else if (!w_kl) begin
          r_pr <= w_prod;
          r_k <= r_k + 2'd1;
        end else begin
          r_acc <= w_acc;
          r_k <= '0;
          r_t <= r_t + 5'd1;
          if (w_tl) begin
            r_st <= DONE;
            r_done <= 1'b1;
            r_det <= w_det;
            r_ovf <= w_hi | w_lo;
            r_err <= 1'b0;
          end
        end
        default: begin
          r_st <= IDLE;
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.det = r_det;
  assign bus.overflow = r_ovf;
  assign bus.error = r_err;
endmodule
